tristate_bus_ctrl: RTL

TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

---
 rtl/tristate_bus_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/tristate_bus_ctrl.sv
// Round-robin owner of a shared tristate bus: one-cycle grant latency, bounded hold,
// and a guaranteed idle turnaround gap between owners.
module tristate_bus_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int MAXHOLD = 4,
    parameter int TURN    = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCH-1:0]           REQ,
    input  logic [NCH*WIDTH-1:0]     DIN,
    output logic [NCH-1:0]           GNT,
    output logic [WIDTH-1:0]         BUS,
    output logic                     BUS_EN,
    output logic [$clog2(NCH)-1:0]   OWNER
);

    localparam int IW = $clog2(NCH);
    localparam logic [7:0]     HOLD_MAX = 8'(MAXHOLD);
    localparam logic [3:0]     TURN_LEN = 4'(TURN);
    localparam logic [NCH-1:0] ONE      = NCH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [7:0]     hold_cnt;
    logic [3:0]     turn_cnt;
    logic [IW-1:0]  winner;
    logic [WIDTH-1:0] bus_data;

    // First requester at or above ptr, wrapping past NCH-1 back to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        logic          found;
        int            j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(p) + k;
            if (j >= NCH) j = j - NCH;
            if (!found && r[j]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(REQ, ptr);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (OWNER == IW'(i)) bus_data = DIN[i*WIDTH +: WIDTH];
        end
    end

    // DIN reaches the bus combinationally; BUS_EN is registered so reset releases it at once.
    assign BUS = BUS_EN ? bus_data : {WIDTH{1'bz}};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            GNT      <= '0;
            BUS_EN   <= 1'b0;
            OWNER    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        state    <= ST_GRANT;
                        GNT      <= ONE << winner;
                        BUS_EN   <= 1'b1;
                        OWNER    <= winner;
                        hold_cnt <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (!REQ[OWNER] || hold_cnt == HOLD_MAX) begin
                        state    <= ST_TURN;
                        GNT      <= '0;
                        BUS_EN   <= 1'b0;
                        ptr      <= (OWNER == IW'(NCH-1)) ? '0 : OWNER + 1'b1;
                        hold_cnt <= '0;
                        turn_cnt <= 4'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_LEN) begin
                        state    <= ST_IDLE;
                        turn_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
